fifo_csr_master: RTL and testbench

Parametrised, register-mapped FIFO master: the next generation of the 8-bit single-FIFO master, with configurable data width and depth, an occupancy counter, a programmable level threshold, sticky write-1-to-clear error flags, flush control and an interrupt output. It sits between a simple enable/addr/read/write register bus and an internal synchronous FIFO. All bus accesses complete with a one-cycle registered response.

---
 rtl/fifo_csr_pkg.sv | 19 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/fifo_csr_master.sv | 156 +++++++++++++++
 tb/tb_fifo_csr_master.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_csr_pkg.sv
// Shared register map and bit positions for the register-mapped FIFO master.
package fifo_csr_pkg;

   localparam int REG_DATA   = 0;
   localparam int REG_STAT   = 1;
   localparam int REG_LEVEL  = 2;
   localparam int REG_CTRL   = 3;
   localparam int REG_THRESH = 4;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_OVF   = 2;
   localparam int STAT_UNF   = 3;
   localparam int STAT_THR   = 4;

   localparam int CTRL_FLUSH  = 0;
   localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is presented combinationally.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is deliberately not reset; contents are don't-care when empty.
   always_ff @(posedge clk) begin
      if (push && !full && !flush)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = CNT_W'(wr_ptr - rd_ptr);
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fifo_csr_master.sv
// Register-bus front end for sync_fifo: decode, sticky error flags, threshold,
// flush/irq control and a one-cycle registered response path.
module fifo_csr_master
   import fifo_csr_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              resp,
   output logic              err,
   output logic              irq
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_level;
   logic [DATA_W-1:0] fifo_head;
   logic              push;
   logic              pop;
   logic              flush;

   logic              ovf_q;
   logic              unf_q;
   logic              irq_en_q;
   logic [CNT_W-1:0]  thresh_q;

   logic              ovf_set;
   logic              unf_set;
   logic              ovf_clr;
   logic              unf_clr;
   logic              ctrl_wr;
   logic              thresh_wr;
   logic              err_d;
   logic [DATA_W-1:0] rdata_d;
   logic              thresh_hit;
   logic [31:0]       reg_sel;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wdata),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign reg_sel    = 32'(addr);
   assign thresh_hit = (fifo_level >= thresh_q);

   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      ovf_clr   = 1'b0;
      unf_clr   = 1'b0;
      ctrl_wr   = 1'b0;
      thresh_wr = 1'b0;
      err_d     = 1'b0;
      rdata_d   = '0;
      if (enable && read && write) begin
         err_d = 1'b1;
      end else if (enable && (read || write)) begin
         case (reg_sel)
            REG_DATA:
               if (write) begin
                  if (fifo_full) begin
                     ovf_set = 1'b1;
                     err_d   = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end else if (fifo_empty) begin
                  unf_set = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  pop     = 1'b1;
                  rdata_d = fifo_head;
               end
            REG_STAT:
               if (write) begin
                  ovf_clr = wdata[STAT_OVF];
                  unf_clr = wdata[STAT_UNF];
               end else begin
                  rdata_d[STAT_FULL]  = fifo_full;
                  rdata_d[STAT_EMPTY] = fifo_empty;
                  rdata_d[STAT_OVF]   = ovf_q;
                  rdata_d[STAT_UNF]   = unf_q;
                  rdata_d[STAT_THR]   = thresh_hit;
               end
            REG_LEVEL:
               if (read)
                  rdata_d[CNT_W-1:0] = fifo_level;
            REG_CTRL:
               if (write) begin
                  flush   = wdata[CTRL_FLUSH];
                  ctrl_wr = 1'b1;
               end else begin
                  rdata_d[CTRL_IRQ_EN] = irq_en_q;
               end
            REG_THRESH:
               if (write)
                  thresh_wr = 1'b1;
               else
                  rdata_d[CNT_W-1:0] = thresh_q;
            default:
               err_d = 1'b1;
         endcase
      end
   end

   // Sticky flags: a set on the same edge as a write-1-to-clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp     <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         irq      <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         thresh_q <= CNT_W'(DEPTH / 2);
      end else begin
         resp  <= enable;
         err   <= err_d;
         rdata <= rdata_d;
         irq   <= irq_en_q & (ovf_q | unf_q | thresh_hit);
         ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
         unf_q <= (unf_q & ~unf_clr) | unf_set;
         if (ctrl_wr)
            irq_en_q <= wdata[CTRL_IRQ_EN];
         if (thresh_wr)
            thresh_q <= wdata[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_fifo_csr_master.sv
// Self-checking bench for fifo_csr_master (DEPTH=4) against a queue-based reference model.
module tb_fifo_csr_master;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       write;
   logic       read;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       resp;
   logic       err;
   logic       irq;

   always #5 clk = ~clk;

   fifo_csr_master #(
      .DATA_W (8),
      .DEPTH  (DEPTH),
      .ADDR_W (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .addr   (addr),
      .write  (write),
      .read   (read),
      .wdata  (wdata),
      .rdata  (rdata),
      .resp   (resp),
      .err    (err),
      .irq    (irq)
   );

   int checks = 0;
   int errors = 0;

   byte unsigned m_q[$];
   bit           m_ovf;
   bit           m_unf;
   bit           m_irq_en;
   int           m_thresh;

   logic [7:0] exp_rdata;
   logic       exp_resp;
   logic       exp_err;
   logic       exp_irq;
   logic [7:0] got_rdata;
   logic       got_resp;
   logic       got_err;
   logic       got_irq;

   task automatic model_reset();
      m_q.delete();
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      m_irq_en  = 1'b0;
      m_thresh  = DEPTH / 2;
      exp_rdata = 8'h00;
      exp_resp  = 1'b0;
      exp_err   = 1'b0;
      exp_irq   = 1'b0;
   endtask

   task automatic model_access(input logic en, input logic wr, input logic rd,
                               input logic [2:0] a, input logic [7:0] wd);
      bit irq_n;
      irq_n     = m_irq_en && (m_ovf || m_unf || (m_q.size() >= m_thresh));
      exp_resp  = en;
      exp_err   = 1'b0;
      exp_rdata = 8'h00;
      if (en && wr && rd) begin
         exp_err = 1'b1;
      end else if (en && (wr || rd)) begin
         case (a)
            3'd0:
               if (wr) begin
                  if (m_q.size() == DEPTH) begin m_ovf = 1'b1; exp_err = 1'b1; end
                  else m_q.push_back(wd);
               end else if (m_q.size() == 0) begin
                  m_unf = 1'b1; exp_err = 1'b1;
               end else begin
                  exp_rdata = m_q.pop_front();
               end
            3'd1:
               if (rd) exp_rdata = {3'b000, m_q.size() >= m_thresh, m_unf, m_ovf,
                                    m_q.size() == 0, m_q.size() == DEPTH};
               else begin
                  if (wd[2]) m_ovf = 1'b0;
                  if (wd[3]) m_unf = 1'b0;
               end
            3'd2: if (rd) exp_rdata = 8'(m_q.size());
            3'd3:
               if (rd) exp_rdata = {6'b0, m_irq_en, 1'b0};
               else begin
                  if (wd[0]) m_q.delete();
                  m_irq_en = wd[1];
               end
            3'd4:
               if (rd) exp_rdata = 8'(m_thresh);
               else m_thresh = int'(wd[2:0]);
            default: exp_err = 1'b1;
         endcase
      end
      exp_irq = irq_n;
   endtask

   task automatic bus(input logic en, input logic wr, input logic rd,
                      input logic [2:0] a, input logic [7:0] wd);
      @(negedge clk);
      enable = en; write = wr; read = rd; addr = a; wdata = wd;
      model_access(en, wr, rd, a, wd);
      @(posedge clk);
      #1;
      got_rdata = rdata; got_resp = resp; got_err = err; got_irq = irq;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({resp, err, rdata, irq} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got resp=%b err=%b rdata=%h irq=%b required all 0", resp, err, rdata, irq);
      end
      @(negedge clk);
      rst = 1'b0;
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata !== 8'h02 || got_err !== 1'b0 || got_resp !== 1'b1) begin
         errors++;
         $display("FAIL reset_stat got rdata=%h err=%b resp=%b required rdata=02 err=0 resp=1", got_rdata, got_err, got_resp);
      end
      bus(1, 0, 1, 3'd4, 8'h00);
      checks++;
      if (got_rdata !== 8'h02) begin
         errors++;
         $display("FAIL reset_thresh got %h required 02", got_rdata);
      end
   endtask

   task automatic test_basic();
      logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         bus(1, 1, 0, 3'd0, vals[i]);
         checks++;
         if (got_resp !== 1'b1 || got_err !== 1'b0 || got_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL basic_push%0d got resp=%b err=%b rdata=%h required resp=1 err=0 rdata=%h", i, got_resp, got_err, got_rdata, exp_rdata);
         end
      end
      bus(1, 0, 1, 3'd2, 8'h00);
      checks++;
      if (got_rdata !== 8'd3) begin
         errors++;
         $display("FAIL basic_level got %h required 03", got_rdata);
      end
      for (int i = 0; i < 3; i++) begin
         bus(1, 0, 1, 3'd0, 8'h00);
         checks++;
         if (got_rdata !== vals[i] || got_resp !== 1'b1 || got_err !== 1'b0 || got_irq !== exp_irq) begin
            errors++;
            $display("FAIL basic_pop%0d got rdata=%h resp=%b err=%b irq=%b required rdata=%h resp=1 err=0 irq=%b", i, got_rdata, got_resp, got_err, got_irq, vals[i], exp_irq);
         end
      end
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata[1] !== 1'b1 || got_rdata !== exp_rdata) begin
         errors++;
         $display("FAIL basic_stat_empty got %h required %h", got_rdata, exp_rdata);
      end
   endtask

   task automatic test_overflow();
      bus(1, 1, 0, 3'd4, 8'h07);
      for (int i = 0; i < 5; i++) begin
         bus(1, 1, 0, 3'd0, 8'hA0 + 8'(i));
         checks++;
         if (got_err !== exp_err || (i == 4 && got_err !== 1'b1)) begin
            errors++;
            $display("FAIL ovf_push%0d got err=%b required err=%b", i, got_err, exp_err);
         end
      end
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata !== 8'h05) begin
         errors++;
         $display("FAIL ovf_stat got %h required 05", got_rdata);
      end
      for (int i = 0; i < 5; i++) begin
         bus(1, 0, 1, 3'd0, 8'h00);
         checks++;
         if (got_rdata !== exp_rdata || got_err !== exp_err || got_rdata === 8'hA4) begin
            errors++;
            $display("FAIL ovf_pop%0d got rdata=%h err=%b required rdata=%h err=%b", i, got_rdata, got_err, exp_rdata, exp_err);
         end
      end
      bus(1, 1, 0, 3'd1, 8'h0C);
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata !== 8'h02) begin
         errors++;
         $display("FAIL ovf_w1c got %h required 02", got_rdata);
      end
   endtask

   task automatic test_underflow();
      bus(1, 0, 1, 3'd0, 8'h00);
      checks++;
      if (got_rdata !== 8'h00 || got_err !== 1'b1 || got_resp !== 1'b1) begin
         errors++;
         $display("FAIL unf_pop got rdata=%h err=%b resp=%b required rdata=00 err=1 resp=1", got_rdata, got_err, got_resp);
      end
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata[3] !== 1'b1 || got_rdata !== exp_rdata) begin
         errors++;
         $display("FAIL unf_stat_set got %h required %h", got_rdata, exp_rdata);
      end
      bus(1, 1, 0, 3'd1, 8'h08);
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata[3] !== 1'b0) begin
         errors++;
         $display("FAIL unf_w1c got %h required bit3=0", got_rdata);
      end
      bus(1, 1, 0, 3'd1, 8'h08);
      bus(1, 0, 1, 3'd0, 8'h00);
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata[3] !== 1'b1) begin
         errors++;
         $display("FAIL unf_reset_after_clear got %h required bit3=1", got_rdata);
      end
      bus(1, 1, 0, 3'd1, 8'h08);
   endtask

   task automatic test_irq();
      bus(1, 1, 0, 3'd4, 8'h02);
      bus(1, 1, 0, 3'd3, 8'h02);
      bus(1, 1, 0, 3'd0, 8'h5A);
      bus(1, 1, 0, 3'd0, 8'h5B);
      checks++;
      if (got_irq !== 1'b0 || got_irq !== exp_irq) begin
         errors++;
         $display("FAIL irq_early got %b required 0", got_irq);
      end
      bus(1, 0, 1, 3'd1, 8'h00);
      checks++;
      if (got_rdata[4] !== 1'b1 || got_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise got stat=%h irq=%b required stat[4]=1 irq=1", got_rdata, got_irq);
      end
      bus(1, 1, 0, 3'd3, 8'h03);
      bus(1, 0, 1, 3'd2, 8'h00);
      checks++;
      if (got_rdata !== 8'h00 || got_irq !== 1'b0 || got_irq !== exp_irq) begin
         errors++;
         $display("FAIL irq_flush got level=%h irq=%b required level=00 irq=0", got_rdata, got_irq);
      end
      bus(1, 1, 0, 3'd3, 8'h00);
   endtask

   task automatic test_wrap();
      bus(1, 1, 0, 3'd0, 8'(($urandom)));
      bus(1, 1, 0, 3'd0, 8'(($urandom)));
      for (int i = 0; i < 10; i++) begin
         if ((i % 3) != 2) bus(1, 1, 0, 3'd0, 8'($urandom));
         else bus(1, 0, 1, 3'd0, 8'h00);
         bus(1, 0, 1, 3'd0, 8'h00);
         checks++;
         if (got_rdata !== exp_rdata || got_err !== exp_err || got_irq !== exp_irq) begin
            errors++;
            $display("FAIL wrap_pop%0d got rdata=%h err=%b irq=%b required rdata=%h err=%b irq=%b", i, got_rdata, got_err, got_irq, exp_rdata, exp_err, exp_irq);
         end
         bus(1, 0, 1, 3'd1, 8'h00);
         checks++;
         if (got_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL wrap_stat%0d got %h required %h", i, got_rdata, exp_rdata);
         end
      end
   endtask

   task automatic test_random();
      logic       en, wr, rd;
      logic [2:0] a;
      logic [7:0] wd;
      int         r;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         a  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
         r  = $urandom_range(0, 9);
         wr = (r <= 4) || (r == 9);
         rd = (r >= 5);
         wd = 8'($urandom);
         if (a == 3'd3) wd[0] = ($urandom_range(0, 7) == 0);
         bus(en, wr, rd, a, wd);
         checks++;
         if ({got_resp, got_err, got_rdata, got_irq} !== {exp_resp, exp_err, exp_rdata, exp_irq}) begin
            errors++;
            $display("FAIL random%0d a=%0d wr=%b rd=%b got resp=%b err=%b rdata=%h irq=%b required resp=%b err=%b rdata=%h irq=%b",
                     i, a, wr, rd, got_resp, got_err, got_rdata, got_irq, exp_resp, exp_err, exp_rdata, exp_irq);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus(1, 1, 0, 3'd4, 8'h03);
      bus(1, 1, 0, 3'd3, 8'h01);
      for (int i = 0; i < 3; i++) bus(1, 1, 0, 3'd0, 8'hC0 + 8'(i));
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; read = 1'b1; write = 1'b0; addr = 3'd0;
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if ({resp, err, rdata, irq} !== 11'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs got resp=%b err=%b rdata=%h irq=%b required all 0", resp, err, rdata, irq);
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
      bus(1, 0, 1, 3'd2, 8'h00);
      checks++;
      if (got_rdata !== 8'h00 || got_resp !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_level got %h resp=%b required 00 resp=1", got_rdata, got_resp);
      end
      bus(1, 0, 1, 3'd4, 8'h00);
      checks++;
      if (got_rdata !== 8'h02) begin
         errors++;
         $display("FAIL rst_mid_thresh got %h required 02", got_rdata);
      end
   endtask

   task automatic test_unmapped();
      bus(1, 0, 1, 3'd6, 8'h00);
      checks++;
      if (got_rdata !== 8'h00 || got_err !== 1'b1 || got_resp !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_read got rdata=%h err=%b resp=%b required rdata=00 err=1 resp=1", got_rdata, got_err, got_resp);
      end
      bus(1, 1, 0, 3'd7, 8'hFF);
      checks++;
      if (got_err !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_write got err=%b required 1", got_err);
      end
      bus(1, 1, 1, 3'd0, 8'h77);
      checks++;
      if (got_err !== 1'b1 || got_resp !== 1'b1) begin
         errors++;
         $display("FAIL both_rw got err=%b resp=%b required err=1 resp=1", got_err, got_resp);
      end
      bus(1, 1, 0, 3'd2, 8'h55);
      checks++;
      if (got_err !== 1'b0) begin
         errors++;
         $display("FAIL level_write got err=%b required 0", got_err);
      end
      bus(1, 0, 1, 3'd2, 8'h00);
      checks++;
      if (got_rdata !== 8'h00) begin
         errors++;
         $display("FAIL both_rw_no_push got level=%h required 00", got_rdata);
      end
      bus(0, 0, 1, 3'd6, 8'h00);
      checks++;
      if (got_resp !== 1'b0 || got_err !== 1'b0) begin
         errors++;
         $display("FAIL idle got resp=%b err=%b required 0 0", got_resp, got_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_irq();
      test_wrap();
      test_random();
      test_reset_mid();
      test_unmapped();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
